bus_datapath_seq: RTL and testbench

Parametrised successor to the 8-bit internal-bus datapath: a WIDTH-bit, NREGS-entry register file with operand latches, ALU, NVZC status and a sequencing FSM that executes one command per handshake. Memory accesses use a two-register {high,low} address and a req/ack handshake with wait states and timeout. Sits between the future instruction decoder (command side) and the memory/bus interface.

---
 rtl/bus_datapath_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_datapath_seq.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
`timescale 1ns/1ps
// WIDTH-bit register-file datapath: operand latches, ALU, NVZC flags, and a
// three-process sequencer that runs one command per handshake, with memory access.
module bus_datapath_seq #(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 4,
    parameter int MAX_WAIT = 15,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [RW-1:0]        cmd_rd,
    input  logic [RW-1:0]        cmd_ra,
    input  logic [RW-1:0]        cmd_rb,
    input  logic [WIDTH-1:0]     cmd_imm,
    output logic                 done,
    output logic                 err,
    output logic [3:0]           flags,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [2*WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_ack,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_EOR  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_INCW = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_SETC = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_EXEC, S_MEM} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [NREGS];
    logic [3:0]       op_q;
    logic [RW-1:0]    rd_q, ra_q, rb_q, rd_p1;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q, b_q, d_q, e_q;
    logic             n_q, v_q, z_q, c_q;
    logic [CW-1:0]    wait_cnt;

    logic               accept, is_mem_op, illegal, timeout;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [2*WIDTH:0]   incw_w;
    logic [WIDTH-1:0]   res, res_hi;
    logic               wr_lo, wr_hi, upd_zn;
    logic               n_n, v_n, z_n, c_n;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; the offerer holds its fields until then.
    assign accept    = cmd_valid && cmd_ready;
    assign is_mem_op = (op_q == OP_LD) || (op_q == OP_ST);
    assign illegal   = (op_q > OP_SETC);
    assign timeout   = (state == S_MEM) && !mem_ack && (wait_cnt == CW'(MAX_WAIT - 1));
    assign rd_p1     = rd_q + 1'b1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LATCH;
            S_LATCH: state_nxt = is_mem_op ? S_MEM : S_EXEC;
            S_EXEC:  state_nxt = S_IDLE;
            S_MEM:   if (mem_ack || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_ready = (state == S_IDLE);
        done      = (state == S_EXEC) || ((state == S_MEM) && (mem_ack || timeout));
        err       = ((state == S_EXEC) && illegal) || timeout;
        mem_req   = (state == S_MEM);
        mem_we    = (state == S_MEM) && (op_q == OP_ST);
        mem_addr  = (state == S_MEM) ? {a_q, b_q} : '0;
        mem_wdata = (state == S_MEM) ? d_q : '0;
    end

    assign flags     = {n_q, v_q, z_q, c_q};
    assign dbg_state = state;

    // SUB adds ~B plus carry, so carry out means "no borrow".
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
    assign diff_w = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, c_q};
    assign incw_w = {1'b0, e_q, d_q} + {{(2*WIDTH){1'b0}}, 1'b1};

    always_comb begin
        res    = '0;
        res_hi = '0;
        wr_lo  = 1'b0;
        wr_hi  = 1'b0;
        upd_zn = 1'b0;
        n_n    = n_q;
        v_n    = v_q;
        z_n    = z_q;
        c_n    = c_q;
        case (op_q)
            OP_MOV: begin res = a_q;     wr_lo = 1'b1; upd_zn = 1'b1; end
            OP_LDI: begin res = imm_q;   wr_lo = 1'b1; upd_zn = 1'b1; end
            OP_AND: begin res = a_q & b_q; wr_lo = 1'b1; upd_zn = 1'b1; end
            OP_OR:  begin res = a_q | b_q; wr_lo = 1'b1; upd_zn = 1'b1; end
            OP_EOR: begin res = a_q ^ b_q; wr_lo = 1'b1; upd_zn = 1'b1; end
            OP_ADD: begin
                res    = sum_w[WIDTH-1:0];
                wr_lo  = 1'b1;
                upd_zn = 1'b1;
                c_n    = sum_w[WIDTH];
                v_n    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res    = diff_w[WIDTH-1:0];
                wr_lo  = 1'b1;
                upd_zn = 1'b1;
                c_n    = diff_w[WIDTH];
                v_n    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SHR: begin
                res    = a_q >> 1;
                wr_lo  = 1'b1;
                upd_zn = 1'b1;
                c_n    = a_q[0];
            end
            OP_INCW: begin
                res    = incw_w[WIDTH-1:0];
                res_hi = incw_w[2*WIDTH-1:WIDTH];
                wr_lo  = 1'b1;
                wr_hi  = 1'b1;
                z_n    = (incw_w[2*WIDTH-1:0] == '0);
                n_n    = incw_w[2*WIDTH-1];
                c_n    = incw_w[2*WIDTH];
            end
            OP_SETC: c_n = imm_q[0];
            default: ;
        endcase
        if (upd_zn) begin
            z_n = (res == '0);
            n_n = res[WIDTH-1];
        end
    end

    // ---------------- datapath state ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            regs     <= '{default: '0};
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            e_q      <= '0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                ra_q  <= cmd_ra;
                rb_q  <= cmd_rb;
                imm_q <= cmd_imm;
            end
            // Operands are snapshotted here, so rd may alias ra/rb freely.
            if (state == S_LATCH) begin
                a_q      <= regs[ra_q];
                b_q      <= regs[rb_q];
                d_q      <= regs[rd_q];
                e_q      <= regs[rd_p1];
                wait_cnt <= '0;
            end
            if (state == S_EXEC) begin
                if (wr_lo) regs[rd_q]  <= res;
                if (wr_hi) regs[rd_p1] <= res_hi;
                n_q <= n_n;
                v_q <= v_n;
                z_q <= z_n;
                c_q <= c_n;
            end
            if (state == S_MEM) begin
                if (mem_ack) begin
                    if (op_q == OP_LD) begin
                        regs[rd_q] <= mem_rdata;
                        z_q        <= (mem_rdata == '0);
                        n_q        <= mem_rdata[WIDTH-1];
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_datapath_seq.sv
`timescale 1ns/1ps
// Self-checking bench for bus_datapath_seq: directed scenarios, a store
// scoreboard for register read-back, and a small model-driven random run.
module tb_bus_datapath_seq;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int RW = 2;

    localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_LDI = 4'd2, OP_ADD = 4'd3,
                           OP_SUB = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_EOR = 4'd7,
                           OP_SHR = 4'd8, OP_INCW = 4'd9, OP_LD = 4'd10, OP_ST = 4'd11,
                           OP_SETC = 4'd12;

    logic            clk, clr, cmd_valid, cmd_ready, done, err;
    logic [3:0]      cmd_op, flags;
    logic [RW-1:0]   cmd_rd, cmd_ra, cmd_rb;
    logic [W-1:0]    cmd_imm, mem_wdata, mem_rdata;
    logic            mem_req, mem_we, mem_ack;
    logic [2*W-1:0]  mem_addr;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [3*W-1:0] exp_q[$];
    logic [3*W-1:0] mon_exp;

    logic [W-1:0] m_r [NR];
    logic         m_n, m_v, m_z, m_c;

    bus_datapath_seq #(.WIDTH(W), .NREGS(NR), .MAX_WAIT(15)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm(cmd_imm), .done(done), .err(err), .flags(flags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- store scoreboard ----------------
    always @(negedge clk) begin
        #1;
        if (mem_req && mem_ack && mem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL store_unexpected: got addr=%h data=%h, none expected", mem_addr, mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL store_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, mon_exp[3*W-1:W], mon_exp[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic offer(input logic [3:0] op, input logic [RW-1:0] rd, ra, rb,
                         input logic [W-1:0] imm, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = cmd_ready;
        if (ok) begin
            cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // ack_after < 0 means the memory never answers.
    task automatic issue(input logic [3:0] op, input logic [RW-1:0] rd, ra, rb,
                         input logic [W-1:0] imm, input int ack_after, input logic [W-1:0] rdata,
                         output int lat, output bit got_err, output int req_cycles,
                         output bit mem_stable, output bit busy_ready, output bit ready_after,
                         output bit seen_we);
        bit ok;
        logic [2*W-1:0] a0;
        logic [W-1:0]   d0;
        logic           we0;
        lat = -1; got_err = 0; req_cycles = 0; mem_stable = 1; busy_ready = 0;
        ready_after = 0; seen_we = 0;
        offer(op, rd, ra, rb, imm, ok);
        if (!ok) return;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    a0 = mem_addr; d0 = mem_wdata; we0 = mem_we; seen_we = mem_we;
                end else if (mem_addr !== a0 || mem_wdata !== d0 || mem_we !== we0) begin
                    mem_stable = 0;
                end
                if (ack_after >= 0 && req_cycles == ack_after + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            #1;
            if (cmd_ready) busy_ready = 1;
            if (done) begin
                lat = c;
                got_err = err;
                break;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1 ready_after = cmd_ready;
    endtask

    // Read a register back through a store with address {R[r],R[r]}.
    task automatic check_reg(input logic [RW-1:0] r, input logic [W-1:0] v);
        int lat, rq; bit ge, st, br, ra_, we;
        exp_q.push_back({v, v, v});
        issue(OP_ST, r, r, r, '0, 0, '0, lat, ge, rq, st, br, ra_, we);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, done, err, mem_req, mem_we} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got rdy/done/err/req/we=%b, expected 10000",
                     {cmd_ready, done, err, mem_req, mem_we});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || flags !== 4'b0000 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h flags=%b state=%0d, expected all zero",
                     mem_addr, mem_wdata, flags, dbg_state);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_alu_basic;
        int lat, rq; bit ge, st, br, ra_, we;
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h7F, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 2 || ge !== 1'b0 || br !== 1'b0 || ra_ !== 1'b1) begin
            n_errors++;
            $display("FAIL ldi_timing: got lat=%0d err=%b busy_ready=%b ready_after=%b, expected 2 0 0 1",
                     lat, ge, br, ra_);
        end
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01, -1, '0, lat, ge, rq, st, br, ra_, we);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 2 || flags !== 4'b1100) begin
            n_errors++;
            $display("FAIL add_flags: got lat=%0d flags=%b, expected lat=2 flags=1100", lat, flags);
        end
        check_reg(2'd3, 8'h80);
        check_reg(2'd1, 8'h7F);
        check_reg(2'd2, 8'h01);
    endtask

    task automatic test_sub_shr;
        int lat, rq; bit ge, st, br, ra_, we;
        issue(OP_SETC, 2'd0, 2'd0, 2'd0, 8'h01, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (flags !== 4'b1101) begin
            n_errors++;
            $display("FAIL setc_flags: got %b, expected 1101", flags);
        end
        issue(OP_SUB, 2'd0, 2'd2, 2'd2, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (flags !== 4'b0011) begin
            n_errors++;
            $display("FAIL sub_flags: got %b, expected 0011", flags);
        end
        check_reg(2'd0, 8'h00);
        issue(OP_SHR, 2'd0, 2'd1, 2'd0, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (flags !== 4'b0001) begin
            n_errors++;
            $display("FAIL shr_flags: got %b, expected 0001", flags);
        end
        check_reg(2'd0, 8'h3F);
    endtask

    task automatic test_incw;
        int lat, rq; bit ge, st, br, ra_, we;
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'hFF, -1, '0, lat, ge, rq, st, br, ra_, we);
        issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'hFF, -1, '0, lat, ge, rq, st, br, ra_, we);
        issue(OP_INCW, 2'd2, 2'd0, 2'd0, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 2 || flags !== 4'b0011) begin
            n_errors++;
            $display("FAIL incw_wrap_flags: got lat=%0d flags=%b, expected 2 0011", lat, flags);
        end
        check_reg(2'd2, 8'h00);
        check_reg(2'd3, 8'h00);
        issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'hFF, -1, '0, lat, ge, rq, st, br, ra_, we);
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        issue(OP_INCW, 2'd3, 2'd0, 2'd0, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (flags !== 4'b0000) begin
            n_errors++;
            $display("FAIL incw_pair_flags: got %b, expected 0000", flags);
        end
        check_reg(2'd3, 8'h00);
        check_reg(2'd0, 8'h01);
    endtask

    task automatic test_mem;
        int lat, rq; bit ge, st, br, ra_, we;
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h12, -1, '0, lat, ge, rq, st, br, ra_, we);
        issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h34, -1, '0, lat, ge, rq, st, br, ra_, we);
        exp_q.push_back({16'h1234, 8'h7F});
        issue(OP_ST, 2'd1, 2'd2, 2'd3, 8'h00, 3, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 5 || rq !== 4 || ge !== 1'b0 || st !== 1'b1 || we !== 1'b1) begin
            n_errors++;
            $display("FAIL st_wait: got lat=%0d req=%0d err=%b stable=%b we=%b, expected 5 4 0 1 1",
                     lat, rq, ge, st, we);
        end
        n_checks++;
        if (flags !== 4'b0000) begin
            n_errors++;
            $display("FAIL st_flags: got %b, expected 0000", flags);
        end
        issue(OP_LD, 2'd0, 2'd2, 2'd3, 8'h00, 0, 8'h00, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 2 || ge !== 1'b0 || we !== 1'b0 || flags !== 4'b0010) begin
            n_errors++;
            $display("FAIL ld_zero: got lat=%0d err=%b we=%b flags=%b, expected 2 0 0 0010",
                     lat, ge, we, flags);
        end
        check_reg(2'd0, 8'h00);
        issue(OP_LD, 2'd1, 2'd2, 2'd3, 8'h00, 1, 8'hC3, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 3 || flags !== 4'b1000) begin
            n_errors++;
            $display("FAIL ld_neg: got lat=%0d flags=%b, expected 3 1000", lat, flags);
        end
        check_reg(2'd1, 8'hC3);
    endtask

    task automatic test_timeout_illegal;
        int lat, rq; bit ge, st, br, ra_, we;
        issue(OP_LD, 2'd1, 2'd2, 2'd3, 8'h00, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 16 || rq !== 15 || ge !== 1'b1 || st !== 1'b1) begin
            n_errors++;
            $display("FAIL ld_timeout: got lat=%0d req=%0d err=%b stable=%b, expected 16 15 1 1",
                     lat, rq, ge, st);
        end
        n_checks++;
        if (flags !== 4'b1000) begin
            n_errors++;
            $display("FAIL timeout_flags: got %b, expected 1000", flags);
        end
        check_reg(2'd1, 8'hC3);
        issue(4'd14, 2'd1, 2'd2, 2'd3, 8'h55, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 2 || ge !== 1'b1 || rq !== 0 || flags !== 4'b1000) begin
            n_errors++;
            $display("FAIL illegal_op: got lat=%0d err=%b req=%0d flags=%b, expected 2 1 0 1000",
                     lat, ge, rq, flags);
        end
        check_reg(2'd1, 8'hC3);
        issue(OP_NOP, 2'd1, 2'd2, 2'd3, 8'h55, -1, '0, lat, ge, rq, st, br, ra_, we);
        n_checks++;
        if (lat !== 2 || ge !== 1'b0 || flags !== 4'b1000) begin
            n_errors++;
            $display("FAIL nop: got lat=%0d err=%b flags=%b, expected 2 0 1000", lat, ge, flags);
        end
        check_reg(2'd1, 8'hC3);
    endtask

    task automatic test_back_to_back;
        logic [5:0] rdy_seen, done_seen;
        int guard = 0;
        rdy_seen = '0; done_seen = '0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_op = OP_LDI; cmd_rd = 2'd0; cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_imm = 8'h11;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_rd = 2'd1; cmd_imm = 8'h22;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 4) cmd_valid = 1'b0;
            #1;
            rdy_seen[c-1]  = cmd_ready;
            done_seen[c-1] = done;
        end
        n_checks++;
        if (rdy_seen !== 6'b100100 || done_seen !== 6'b010010) begin
            n_errors++;
            $display("FAIL back_to_back: got ready=%b done=%b, expected 100100 010010",
                     rdy_seen, done_seen);
        end
        check_reg(2'd0, 8'h11);
        check_reg(2'd1, 8'h22);
    endtask

    task automatic test_clr;
        bit ok;
        int dones = 0;
        offer(OP_LD, 2'd2, 2'd0, 2'd1, 8'h00, ok);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_pre: got accepted=%b mem_req=%b, expected 1 1", ok, mem_req);
        end
        #2 clr = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || flags !== 4'b0000) begin
            n_errors++;
            $display("FAIL clr_async: got req=%b rdy=%b done=%b flags=%b, expected 0 1 0 0000",
                     mem_req, cmd_ready, done, flags);
        end
        @(negedge clk);
        clr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1 if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_errors++;
            $display("FAIL clr_no_done: got %0d done pulses, expected 0", dones);
        end
        for (int r = 0; r < NR; r++) check_reg(r[RW-1:0], 8'h00);
    endtask

    task automatic test_random;
        int lat, rq; bit ge, st, br, ra_, we;
        logic [3:0] ops [10];
        logic [3:0] op;
        logic [RW-1:0] rd, ra, rb, rh;
        logic [W-1:0] imm, a, b, res;
        int t, sa, sb, sr, p;
        bit wr;
        ops = '{OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR, OP_SHR, OP_SETC, OP_INCW};
        for (int i = 0; i < NR; i++) m_r[i] = '0;
        {m_n, m_v, m_z, m_c} = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            op  = (i < 4) ? OP_LDI : ops[$urandom_range(0, 9)];
            rd  = (i < 4) ? i[RW-1:0] : RW'($urandom_range(0, NR - 1));
            ra  = RW'($urandom_range(0, NR - 1));
            rb  = RW'($urandom_range(0, NR - 1));
            imm = W'($urandom_range(0, 255));
            a = m_r[ra]; b = m_r[rb]; sa = $signed(a); sb = $signed(b);
            res = '0; wr = 1;
            case (op)
                OP_LDI: res = imm;
                OP_MOV: res = a;
                OP_AND: res = a & b;
                OP_OR:  res = a | b;
                OP_EOR: res = a ^ b;
                OP_ADD: begin
                    t = int'(a) + int'(b) + int'(m_c);
                    sr = sa + sb + int'(m_c);
                    res = t[W-1:0]; m_c = (t > 255); m_v = (sr > 127) || (sr < -128);
                end
                OP_SUB: begin
                    t = int'(a) - int'(b) - (m_c ? 0 : 1);
                    sr = sa - sb - (m_c ? 0 : 1);
                    res = t[W-1:0]; m_c = (t >= 0); m_v = (sr > 127) || (sr < -128);
                end
                OP_SHR: begin res = a >> 1; m_c = a[0]; end
                OP_SETC: begin wr = 0; m_c = imm[0]; end
                default: begin
                    wr = 0;
                    rh = rd + 1'b1;
                    p = int'({m_r[rh], m_r[rd]}) + 1;
                    m_r[rd] = p[7:0]; m_r[rh] = p[15:8];
                    m_c = p[16]; m_z = (p[15:0] == 0); m_n = p[15];
                end
            endcase
            if (wr) begin
                m_r[rd] = res; m_z = (res == 0); m_n = res[W-1];
            end
            issue(op, rd, ra, rb, imm, -1, '0, lat, ge, rq, st, br, ra_, we);
            n_checks++;
            if (lat !== 2 || ge !== 1'b0 || flags !== {m_n, m_v, m_z, m_c}) begin
                n_errors++;
                $display("FAIL random_op%0d: op=%0d got lat=%0d err=%b flags=%b, expected 2 0 %b",
                         i, op, lat, ge, flags, {m_n, m_v, m_z, m_c});
            end
        end
        for (int r = 0; r < NR; r++) check_reg(r[RW-1:0], m_r[r]);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_imm = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_alu_basic();
        test_sub_shr();
        test_incw();
        test_mem();
        test_timeout_illegal();
        test_back_to_back();
        test_clr();
        test_random();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL store_missing: %0d expected stores never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
